// File: rtl/jtdsp16_sio_pkg.sv
// Shared constants for the DSP16-style serial I/O block: register selects,
// SIOC field positions and the bit-period lookup.
package jtdsp16_sio_pkg;

  localparam logic [2:0] RF_SIOC = 3'd0;
  localparam logic [2:0] RF_SRTA = 3'd1;
  localparam logic [2:0] RF_SDX  = 3'd2;

  localparam int SIOC_IW  = 0;  // input width: 0 = DW bits, 1 = 8 bits
  localparam int SIOC_OW  = 1;  // output width, same encoding
  localparam int SIOC_MSB = 6;  // 1 = MSB first
  localparam int SIOC_CK  = 7;  // [8:7] bit period code

  localparam logic [4:0] P_TAB0 = 5'd4;
  localparam logic [4:0] P_TAB1 = 5'd12;
  localparam logic [4:0] P_TAB2 = 5'd16;
  localparam logic [4:0] P_TAB3 = 5'd20;

  function automatic logic [4:0] bit_period(input logic [1:0] code);
    logic [4:0] p;
    case (code)
      2'd1:    p = P_TAB1;
      2'd2:    p = P_TAB2;
      2'd3:    p = P_TAB3;
      default: p = P_TAB0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/jtdsp16_sio_rx.sv
// Serial input path: synchroniser, ick rising-edge detect, input shifter,
// input buffer and the buffer-full flag.
module jtdsp16_sio_rx #(
  parameter int DW   = 16,
  parameter int SYNC = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ph1,
  input  logic          ick_i,
  input  logic          ild_i,
  input  logic          di_i,
  input  logic          msb_first_i,
  input  logic          w8_i,
  input  logic          rd_clr_i,
  output logic [DW-1:0] ibuf_o,
  output logic          ibf_o
);
  localparam int CW = $clog2(DW + 1);

  logic [2:0]    raw, s;
  logic          ick_prev_q, rise;
  logic [DW-1:0] isr_q, isr_d, isr_n, ibuf_q, ibuf_d;
  logic [CW-1:0] icnt_q, icnt_d, iw;
  logic          ibf_q, ibf_d;

  assign raw = {ick_i, ild_i, di_i};

  if (SYNC == 0) begin : g_nosync
    assign s = raw;
  end else begin : g_sync
    logic [SYNC-1:0][2:0] sync_q;
    always_ff @(posedge clk) begin
      if (rst) sync_q <= {SYNC{3'b010}};
      else if (ph1) begin
        sync_q[0] <= raw;
        for (int i = 1; i < SYNC; i++) sync_q[i] <= sync_q[i-1];
      end
    end
    assign s = sync_q[SYNC-1];
  end

  assign rise  = s[2] & ~ick_prev_q;
  assign iw    = w8_i ? CW'(8) : CW'(DW);
  assign isr_n = msb_first_i ? {isr_q[DW-2:0], s[0]} : {s[0], isr_q[DW-1:1]};

  always_comb begin
    isr_d  = isr_q;
    icnt_d = icnt_q;
    ibuf_d = ibuf_q;
    ibf_d  = ibf_q;
    if (rd_clr_i) ibf_d = 1'b0;
    if (s[1]) icnt_d = '0;
    else if (rise) begin
      isr_d  = isr_n;
      icnt_d = icnt_q + 1'b1;
      // a completion wins over a same-tick read so the new word is not lost
      if (icnt_q + 1'b1 >= iw) begin
        icnt_d = '0;
        ibf_d  = 1'b1;
        if (!w8_i)            ibuf_d = isr_n;
        else if (msb_first_i) ibuf_d = {{(DW-8){1'b0}}, isr_n[7:0]};
        else                  ibuf_d = {{(DW-8){1'b0}}, isr_n[DW-1:DW-8]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ick_prev_q <= 1'b0;
      isr_q      <= '0;
      icnt_q     <= '0;
      ibuf_q     <= '0;
      ibf_q      <= 1'b0;
    end else if (ph1) begin
      ick_prev_q <= s[2];
      isr_q      <= isr_d;
      icnt_q     <= icnt_d;
      ibuf_q     <= ibuf_d;
      ibf_q      <= ibf_d;
    end
  end

  assign ibuf_o = ibuf_q;
  assign ibf_o  = ibf_q;

endmodule

// File: rtl/jtdsp16_sio_gen.sv
// Full-duplex serial port: register file, bit-clock divider and the
// double-buffered output path; the input path lives in jtdsp16_sio_rx.
module jtdsp16_sio_gen import jtdsp16_sio_pkg::*; #(
  parameter int DW   = 16,
  parameter int AW   = 8,
  parameter int SYNC = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ph1,
  input  logic [DW-1:0] long_imm,
  input  logic [DW-1:0] acc_dout,
  input  logic [DW-1:0] ram_dout,
  input  logic          sio_imm_load,
  input  logic          sio_acc_load,
  input  logic          sio_ram_load,
  input  logic          sio_rd,
  input  logic [2:0]    r_field,
  output logic          ock,
  output logic          sio_do,
  output logic          sadd,
  output logic          old,
  output logic          ose,
  output logic          obe,
  input  logic          ick,
  input  logic          ild,
  input  logic          sio_di,
  output logic          ibf,
  output logic [DW-1:0] r_sio,
  output logic [9:0]    debug_sioc
);
  localparam int CW = $clog2(DW + 1);

  logic [DW-1:0] wdata, ibuf;
  logic          wr, wr_sdx;
  logic [9:0]    sioc_q;
  logic [DW-1:0] srta_q;
  logic [4:0]    per, half, div_q;
  logic          ock_q, rise_q, load;

  logic [DW-1:0] obuf_q, obuf_d, osr_q, osr_d;
  logic [AW-1:0] oaddr_q, oaddr_d;
  logic [CW-1:0] ocnt_q, ocnt_d, onbits;
  logic          obe_q, obe_d, ose_q, ose_d, old_q, old_d;
  logic          first_q, first_d, ow8_q, ow8_d, omsb_q, omsb_d;

  always_comb begin
    wdata = ram_dout;
    if (sio_acc_load) wdata = acc_dout;
    if (sio_imm_load) wdata = long_imm;
  end

  assign wr     = sio_imm_load | sio_acc_load | sio_ram_load;
  assign wr_sdx = wr && (r_field == RF_SDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      sioc_q <= '0;
      srta_q <= '0;
    end else if (ph1 && wr) begin
      if (r_field == RF_SIOC) sioc_q <= wdata[9:0];
      if (r_field == RF_SRTA) srta_q <= wdata;
    end
  end

  assign per  = bit_period(sioc_q[SIOC_CK +: 2]);
  assign half = per >> 1;

  // free-running divider; ock only pulses while a word is in the shifter
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      ock_q  <= 1'b0;
      rise_q <= 1'b0;
    end else if (ph1) begin
      div_q  <= (div_q >= per - 5'd1) ? 5'd0 : div_q + 5'd1;
      rise_q <= (div_q == half - 5'd1) && !ose_q;
      if ((div_q == half - 5'd1) && !ose_q) ock_q <= 1'b1;
      else if (div_q >= per - 5'd1)         ock_q <= 1'b0;
    end
  end

  assign onbits = ow8_q ? CW'(8) : CW'(DW);

  always_comb begin
    obuf_d  = obuf_q;
    osr_d   = osr_q;
    oaddr_d = oaddr_q;
    ocnt_d  = ocnt_q;
    obe_d   = obe_q;
    ose_d   = ose_q;
    old_d   = old_q;
    first_d = first_q;
    ow8_d   = ow8_q;
    omsb_d  = omsb_q;
    load    = 1'b0;
    if (ose_q && !obe_q) begin
      load    = 1'b1;
      first_d = 1'b1;
    end else if (rise_q && !ose_q) begin
      if (first_q) begin
        first_d = 1'b0;
        old_d   = 1'b0;
      end else begin
        osr_d   = omsb_q ? osr_q << 1 : osr_q >> 1;
        oaddr_d = oaddr_q << 1;
        ocnt_d  = ocnt_q + 1'b1;
        // frame end: chain the pending word without a framing gap
        if (ocnt_q + 1'b1 == onbits) begin
          if (!obe_q) load = 1'b1;
          else begin
            ose_d = 1'b1;
            old_d = 1'b1;
          end
        end
      end
    end
    if (load) begin
      osr_d   = obuf_q;
      ocnt_d  = '0;
      oaddr_d = srta_q[AW-1:0];
      ow8_d   = sioc_q[SIOC_OW];
      omsb_d  = sioc_q[SIOC_MSB];
      obe_d   = 1'b1;
      ose_d   = 1'b0;
    end
    if (wr_sdx) begin
      obuf_d = wdata;
      obe_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      obuf_q  <= '0;
      osr_q   <= '0;
      oaddr_q <= '0;
      ocnt_q  <= '0;
      obe_q   <= 1'b1;
      ose_q   <= 1'b1;
      old_q   <= 1'b1;
      first_q <= 1'b0;
      ow8_q   <= 1'b0;
      omsb_q  <= 1'b0;
    end else if (ph1) begin
      obuf_q  <= obuf_d;
      osr_q   <= osr_d;
      oaddr_q <= oaddr_d;
      ocnt_q  <= ocnt_d;
      obe_q   <= obe_d;
      ose_q   <= ose_d;
      old_q   <= old_d;
      first_q <= first_d;
      ow8_q   <= ow8_d;
      omsb_q  <= omsb_d;
    end
  end

  jtdsp16_sio_rx #(.DW(DW), .SYNC(SYNC)) u_rx (
    .clk         (clk),
    .rst         (rst),
    .ph1         (ph1),
    .ick_i       (ick),
    .ild_i       (ild),
    .di_i        (sio_di),
    .msb_first_i (sioc_q[SIOC_MSB]),
    .w8_i        (sioc_q[SIOC_IW]),
    .rd_clr_i    (sio_rd && (r_field == RF_SDX)),
    .ibuf_o      (ibuf),
    .ibf_o       (ibf)
  );

  always_comb begin
    r_sio = '0;
    case (r_field)
      RF_SIOC: r_sio = DW'(sioc_q);
      RF_SRTA: r_sio = srta_q;
      RF_SDX:  r_sio = ibuf;
      default: r_sio = '0;
    endcase
  end

  assign ock        = ock_q;
  assign obe        = obe_q;
  assign ose        = ose_q;
  assign old        = old_q;
  assign sadd       = !ose_q && oaddr_q[AW-1];
  assign sio_do     = ose_q ? 1'b0 : (omsb_q ? (ow8_q ? osr_q[7] : osr_q[DW-1]) : osr_q[0]);
  assign debug_sioc = sioc_q;

endmodule

// File: tb/tb_jtdsp16_sio_gen.sv
// Directed bench for jtdsp16_sio_gen: register vector table plus hand-built
// serial frame, input and clock-enable sequences.
module tb_jtdsp16_sio_gen;
  logic        clk = 1'b0, rst = 1'b1, ph1 = 1'b1;
  logic [15:0] long_imm = '0, acc_dout = '0, ram_dout = '0;
  logic        sio_imm_load = 0, sio_acc_load = 0, sio_ram_load = 0, sio_rd = 0;
  logic [2:0]  r_field = '0;
  logic        ock, sio_do, sadd, old, ose, obe, ibf;
  logic        ick = 0, ild = 1, sio_di = 0;
  logic [15:0] r_sio;
  logic [9:0]  debug_sioc;

  int n_vec = 0, n_err = 0;

  jtdsp16_sio_gen #(.DW(16), .AW(8), .SYNC(2)) dut (
    .clk(clk), .rst(rst), .ph1(ph1), .long_imm(long_imm), .acc_dout(acc_dout),
    .ram_dout(ram_dout), .sio_imm_load(sio_imm_load), .sio_acc_load(sio_acc_load),
    .sio_ram_load(sio_ram_load), .sio_rd(sio_rd), .r_field(r_field), .ock(ock),
    .sio_do(sio_do), .sadd(sadd), .old(old), .ose(ose), .obe(obe), .ick(ick),
    .ild(ild), .sio_di(sio_di), .ibf(ibf), .r_sio(r_sio), .debug_sioc(debug_sioc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  ld;   // {ram, acc, imm}
    logic [2:0]  rf;
    logic [15:0] imm, acc, ram;
    logic [15:0] exp_r;
    logic [9:0]  exp_dbg;
  } vec_t;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] rf, input logic [15:0] d);
    r_field = rf; long_imm = d; sio_imm_load = 1;
    tick();
    sio_imm_load = 0;
  endtask

  task automatic wait_fall(output int cyc);
    logic p, done;
    p = ock; done = 0; cyc = 0;
    while (!done && cyc < 200) begin
      tick(); cyc++;
      if (p && !ock) done = 1;
      p = ock;
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL ock_fall_timeout: got none within %0d cycles", cyc);
    end
  endtask

  task automatic pulse(input logic b);
    sio_di = b; ick = 0;
    tick(); tick();
    ick = 1;
    tick(); tick();
  endtask

  initial begin
    vec_t vt[10];
    int c;
    logic [15:0] w16, sa16, d;
    logic [31:0] w32;
    logic [7:0]  w8, sa8;
    logic        oacc, chg;
    logic [6:0]  snap;

    vt[0] = '{3'b001, 3'd0, 16'h03FF, 16'h0000, 16'h0000, 16'h03FF, 10'h3FF};
    vt[1] = '{3'b111, 3'd0, 16'h0111, 16'h0222, 16'h0333, 16'h0111, 10'h111};
    vt[2] = '{3'b110, 3'd1, 16'h0000, 16'hBEEF, 16'h1234, 16'hBEEF, 10'h111};
    vt[3] = '{3'b100, 3'd1, 16'h0000, 16'h0000, 16'h00A5, 16'h00A5, 10'h111};
    vt[4] = '{3'b010, 3'd0, 16'h0000, 16'hFFFF, 16'h0000, 16'h03FF, 10'h3FF};
    vt[5] = '{3'b000, 3'd3, 16'h1111, 16'h2222, 16'h3333, 16'h0000, 10'h3FF};
    vt[6] = '{3'b000, 3'd7, 16'h1111, 16'h2222, 16'h3333, 16'h0000, 10'h3FF};
    vt[7] = '{3'b000, 3'd2, 16'h1111, 16'h2222, 16'h3333, 16'h0000, 10'h3FF};
    vt[8] = '{3'b011, 3'd0, 16'h02C0, 16'h0001, 16'h0000, 16'h02C0, 10'h2C0};
    vt[9] = '{3'b000, 3'd1, 16'h0000, 16'h0000, 16'h0000, 16'h00A5, 10'h2C0};

    repeat (3) tick();
    rst = 0;
    tick();
    chk("rst_ock", ock, 0);   chk("rst_old", old, 1);   chk("rst_ose", ose, 1);
    chk("rst_obe", obe, 1);   chk("rst_do", sio_do, 0); chk("rst_sadd", sadd, 0);
    chk("rst_ibf", ibf, 0);   chk("rst_sioc", debug_sioc, 0); chk("rst_rsio", r_sio, 0);

    for (int i = 0; i < 10; i++) begin
      r_field = vt[i].rf;
      long_imm = vt[i].imm; acc_dout = vt[i].acc; ram_dout = vt[i].ram;
      {sio_ram_load, sio_acc_load, sio_imm_load} = vt[i].ld;
      tick();
      {sio_ram_load, sio_acc_load, sio_imm_load} = 3'b000;
      #1;
      chk($sformatf("vec%0d_rsio", i), r_sio, vt[i].exp_r);
      chk($sformatf("vec%0d_sioc", i), debug_sioc, vt[i].exp_dbg);
    end

    // single 16-bit MSB-first frame, P=12, address 0xA5
    wr(3'd2, 16'h8001);
    chk("t1_obe_wr", obe, 0); chk("t1_ose_wr", ose, 1);
    tick();
    chk("t1_obe_xfer", obe, 1); chk("t1_ose_xfer", ose, 0); chk("t1_old_pre", old, 1);
    w16 = 0; sa16 = 0; oacc = 0;
    for (int i = 0; i < 16; i++) begin
      wait_fall(c);
      if (i == 2) chk("t1_period", c, 12);
      w16 = {w16[14:0], sio_do}; sa16 = {sa16[14:0], sadd}; oacc |= old;
    end
    chk("t1_data", w16, 16'h8001); chk("t1_sadd", sa16, 16'hA500); chk("t1_old_low", oacc, 0);
    wait_fall(c);
    chk("t1_ose_end", ose, 1); chk("t1_old_end", old, 1); chk("t1_do_end", sio_do, 0);

    // back-to-back frames
    wr(3'd2, 16'h1234);
    tick();
    w32 = 0; oacc = 0;
    for (int i = 0; i < 32; i++) begin
      wait_fall(c);
      w32 = {w32[30:0], sio_do}; oacc |= old;
      if (i == 1) begin wr(3'd2, 16'hABCD); chk("t2_obe_wr", obe, 0); end
      if (i == 15) chk("t2_obe_pend", obe, 0);
      if (i == 16) chk("t2_sadd_reload", sadd, 1);
      if (i == 17) chk("t2_obe_xfer", obe, 1);
    end
    chk("t2_data", w32, 32'h1234ABCD); chk("t2_old_low", oacc, 0);
    wait_fall(c);
    chk("t2_ose_end", ose, 1); chk("t2_old_end", old, 1);

    // 8-bit LSB-first frame, P=16
    wr(3'd0, 16'h0102);
    wr(3'd2, 16'h00F0);
    tick();
    w8 = 0; sa8 = 0;
    for (int i = 0; i < 8; i++) begin
      wait_fall(c);
      if (i == 1) chk("t3_period", c, 16);
      w8 = {sio_do, w8[7:1]}; sa8 = {sa8[6:0], sadd};
    end
    chk("t3_data", w8, 8'hF0); chk("t3_sadd", sa8, 8'hA5);
    wait_fall(c);
    chk("t3_ose_end", ose, 1);

    // 16-bit MSB-first input word, then read clears ibf
    wr(3'd0, 16'h02C0);
    r_field = 3'd2; ild = 0;
    repeat (4) tick();
    d = 16'hC3A5;
    for (int i = 15; i >= 1; i--) pulse(d[i]);
    tick(); tick();
    chk("t4_ibf_early", ibf, 0);
    pulse(d[0]);
    ick = 0; tick(); tick();
    chk("t4_ibf", ibf, 1); chk("t4_ibuf", r_sio, 16'hC3A5);
    ild = 1; sio_rd = 1;
    tick();
    sio_rd = 0;
    chk("t4_ibf_clr", ibf, 0);

    // completion on the same tick as a read keeps ibf set
    ild = 0;
    repeat (3) tick();
    d = 16'h5A0F;
    for (int i = 15; i >= 1; i--) pulse(d[i]);
    sio_di = d[0]; ick = 0;
    tick(); tick();
    ick = 1;
    tick(); tick();
    sio_rd = 1;
    tick();
    sio_rd = 0;
    chk("t5_ibf", ibf, 1); chk("t5_ibuf", r_sio, 16'h5A0F);

    // 8-bit LSB-first word overwrites an unread buffer
    wr(3'd0, 16'h0001);
    r_field = 3'd2; ick = 0;
    tick(); tick();
    d = 16'h0096;
    for (int i = 0; i < 8; i++) pulse(d[i]);
    ick = 0; tick(); tick();
    chk("t5_ovw_ibf", ibf, 1); chk("t5_ovw_ibuf", r_sio, 16'h0096);
    ild = 1;

    // clock enable freeze, then reset mid-frame
    wr(3'd0, 16'h02C0);
    wr(3'd2, 16'hFFFF);
    tick();
    repeat (3) wait_fall(c);
    ph1 = 0;
    snap = {ock, sio_do, sadd, old, ose, obe, ibf};
    chk("t6_busy", {old, ose}, 2'b00);
    chg = 0;
    repeat (50) begin
      tick();
      if ({ock, sio_do, sadd, old, ose, obe, ibf} !== snap) chg = 1;
    end
    chk("t6_ph1_hold", chg, 0);
    ph1 = 1;
    repeat (7) tick();
    r_field = 3'd1; rst = 1;
    tick();
    chk("t6_ock", ock, 0); chk("t6_old", old, 1); chk("t6_ose", ose, 1);
    chk("t6_obe", obe, 1); chk("t6_do", sio_do, 0); chk("t6_sadd", sadd, 0);
    chk("t6_ibf", ibf, 0); chk("t6_sioc", debug_sioc, 0); chk("t6_srta", r_sio, 0);
    rst = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
